// File: rtl/ara_pkg.sv
// Shared vector-unit types: element word and operand-queue tags.
package ara_pkg;

  localparam int unsigned ELEN = 64;

  typedef logic [ELEN-1:0] elen_t;

  typedef enum logic [3:0] {
    AluA, AluB, MulFPUA, MulFPUB, MulFPUC, MaskB, MaskM, StA, SlideAddrGenA
  } opqueue_e;

endpackage

// File: rtl/lut_row_fifo.sv
// Full-row FIFO: storage, wrapping pointers and occupancy count; head gated to zero when empty.
module lut_row_fifo
  import ara_pkg::*;
#(
  parameter int unsigned NrBanks = 8,
  parameter int unsigned Depth   = 2,
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  elen_t      [NrBanks-1:0] push_row,
  input  opqueue_e                 push_tag,
  input  logic                     pop,
  output elen_t      [NrBanks-1:0] head_row,
  output opqueue_e                 head_tag,
  output logic                     head_valid,
  output logic       [CntW-1:0]    count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef elen_t [NrBanks-1:0] row_t;

  row_t            mem     [Depth];
  opqueue_e        tag_mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  // Storage carries no reset; the empty-gated head keeps stale words invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]     <= push_row;
      tag_mem[wr_ptr] <= push_tag;
    end
  end

  assign head_valid = (count != '0);
  assign head_row   = head_valid ? mem[rd_ptr] : '0;
  assign head_tag   = head_valid ? tag_mem[rd_ptr] : opqueue_e'('0);

endmodule

// File: rtl/lut_operand_queue.sv
// Credit-reserved operand queue between the lane VRF full-row read port and the LUT unit.
module lut_operand_queue
  import ara_pkg::*;
#(
  parameter int unsigned NrBanks = 8,
  parameter int unsigned Depth   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  elen_t   [NrBanks-1:0] operand_permu_i,
  input  logic                  operand_permu_valid_i,
  input  opqueue_e              operand_permu_opqueue_i,
  input  logic                  issue_req_i,
  output logic                  issue_gnt_o,
  output elen_t   [NrBanks-1:0] lut_operand_o,
  output opqueue_e              lut_opqueue_o,
  output logic                  lut_valid_o,
  input  logic                  lut_ready_i,
  input  logic                  flush_i,
  output logic                  overflow_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  typedef elen_t [NrBanks-1:0] row_t;

  logic [CntW-1:0] reserved_q;
  logic [CntW-1:0] occupancy;
  logic            overflow_q;
  logic            dequeue;
  logic            accept;
  logic            arrival;
  logic            no_slot;
  logic            push;

  // A dequeue under flush is absorbed by the flush itself.
  assign dequeue     = lut_valid_o && lut_ready_i && !flush_i;
  assign issue_gnt_o = !rst_i && !flush_i && ((reserved_q < DepthC) || dequeue);
  assign accept      = issue_req_i && issue_gnt_o;

  // Reserved minus occupancy is the number of reads in flight; none in flight means no slot.
  assign arrival = operand_permu_valid_i && !flush_i;
  assign no_slot = (occupancy == reserved_q);
  assign push    = arrival && !no_slot;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reserved_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (flush_i) reserved_q <= '0;
      else         reserved_q <= reserved_q + CntW'(accept) - CntW'(dequeue);
      if (arrival && no_slot) overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;

  lut_row_fifo #(
    .NrBanks(NrBanks),
    .Depth  (Depth)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .push      (push),
    .push_row  (operand_permu_i),
    .push_tag  (operand_permu_opqueue_i),
    .pop       (dequeue),
    .head_row  (lut_operand_o),
    .head_tag  (lut_opqueue_o),
    .head_valid(lut_valid_o),
    .count     (occupancy)
  );

endmodule

// File: tb/tb_lut_operand_queue.sv
// Bench for lut_operand_queue: VRF read model, row scoreboard, per-cycle table and corner sequences.
module tb_lut_operand_queue;
  import ara_pkg::*;

  localparam int unsigned NrBanks = 8;
  localparam int unsigned Depth   = 2;

  typedef elen_t [NrBanks-1:0] row_t;
  typedef struct { bit req; bit ready; bit exp_gnt; bit exp_valid; } vec_t;
  typedef struct { row_t row; opqueue_e tag; } exp_t;

  logic     clk = 1'b0;
  logic     rst;
  row_t     permu;
  logic     permu_valid;
  opqueue_e permu_tag;
  logic     req;
  logic     gnt;
  row_t     lut_op;
  opqueue_e lut_tag;
  logic     lut_valid;
  logic     ready;
  logic     flush;
  logic     ovf;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop;
  int   k;
  bit   pend;

  always #5 clk = ~clk;

  lut_operand_queue #(.NrBanks(NrBanks), .Depth(Depth)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .operand_permu_i        (permu),
    .operand_permu_valid_i  (permu_valid),
    .operand_permu_opqueue_i(permu_tag),
    .issue_req_i            (req),
    .issue_gnt_o            (gnt),
    .lut_operand_o          (lut_op),
    .lut_opqueue_o          (lut_tag),
    .lut_valid_o            (lut_valid),
    .lut_ready_i            (ready),
    .flush_i                (flush),
    .overflow_o             (ovf)
  );

  function automatic row_t mk_row(input int idx);
    row_t r;
    for (int b = 0; b < NrBanks; b++)
      for (int h = 0; h < ELEN / 16; h++)
        r[b][h*16 +: 16] = {8'(idx * 17), 8'(b)};
    return r;
  endfunction

  function automatic opqueue_e mk_tag(input int idx);
    return opqueue_e'(4'(idx % 9));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input row_t act, input row_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock cycle, entered at the falling edge with control inputs already set.
  task automatic tick(input bit inj, output bit g, output bit v);
    exp_t e;
    if (pend || inj) begin
      permu       = mk_row(k);
      permu_tag   = mk_tag(k);
      permu_valid = 1'b1;
      if (pend && !flush && !rst) begin
        e.row = mk_row(k);
        e.tag = mk_tag(k);
        sb.push_back(e);
      end
      k++;
    end else begin
      permu_valid = 1'b0;
      permu       = '0;
    end
    #1;
    g = gnt;
    v = lut_valid;
    if (!lut_valid) begin
      chk_row("idle_row_zero", lut_op, '0);
      chk("idle_tag_zero", lut_tag, 64'd0);
    end else if (ready && !flush) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_row: got %0h, want no row", lut_op);
      end else begin
        e = sb.pop_front();
        chk_row("row_data", lut_op, e.row);
        chk("row_tag", lut_tag, e.tag);
        n_pop++;
      end
    end
    if (flush) sb.delete();
    pend = req && gnt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit g, v;
    for (int i = 0; i < 12 && (sb.size() != 0 || pend); i++) tick(1'b0, g, v);
    chk("drain_empty", sb.size(), 64'd0);
  endtask

  initial begin
    vec_t tbl[8];
    bit   g, v;
    int   first;
    int   cnt;

    tbl = '{'{1, 0, 1, 0}, '{1, 0, 1, 0}, '{1, 0, 0, 1}, '{1, 0, 0, 1},
            '{1, 1, 1, 1}, '{0, 1, 1, 1}, '{0, 1, 1, 1}, '{0, 1, 1, 0}};

    rst = 1'b1; req = 1'b1; ready = 1'b0; flush = 1'b0;
    permu_valid = 1'b0; permu = '0; permu_tag = AluA;
    pend = 1'b0; k = 0; n_pop = 0;
    repeat (2) @(negedge clk);
    chk("reset_gnt", gnt, 64'd0);
    chk("reset_valid", lut_valid, 64'd0);
    chk("reset_overflow", ovf, 64'd0);
    chk_row("reset_row", lut_op, '0);
    req = 1'b0;
    rst = 1'b0;

    // Sustained streaming
    req = 1'b1; ready = 1'b1; first = -1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, g, v);
      chk("stream_gnt", g, 64'd1);
      if (v && first < 0) first = i;
    end
    req = 1'b0;
    drain();
    chk("stream_first_latency", first, 64'd2);
    chk("stream_rows_out", n_pop, 64'd10);
    chk("stream_overflow", ovf, 64'd0);

    // Backpressure table
    for (int i = 0; i < 8; i++) begin
      req   = tbl[i].req;
      ready = tbl[i].ready;
      tick(1'b0, g, v);
      chk($sformatf("tbl_gnt[%0d]", i), g, tbl[i].exp_gnt);
      chk($sformatf("tbl_valid[%0d]", i), v, tbl[i].exp_valid);
    end
    drain();

    // Flush with A, B stored and C arriving
    req = 1'b1; ready = 1'b0;
    tick(1'b0, g, v);
    tick(1'b0, g, v);
    req = 1'b0;
    tick(1'b0, g, v);
    chk("flush_pre_valid", lut_valid, 64'd1);
    flush = 1'b1;
    tick(1'b1, g, v);
    chk("flush_gnt", g, 64'd0);
    flush = 1'b0;
    tick(1'b0, g, v);
    chk("flush_valid_next", v, 64'd0);
    chk("flush_overflow", ovf, 64'd0);
    req = 1'b1;
    tick(1'b0, g, v);
    chk("flush_regrant0", g, 64'd1);
    tick(1'b0, g, v);
    chk("flush_regrant1", g, 64'd1);
    tick(1'b0, g, v);
    chk("flush_regrant2", g, 64'd0);
    req = 1'b0; ready = 1'b1;
    drain();
    chk("flush_overflow_after", ovf, 64'd0);

    // Row with no reservation
    tick(1'b1, g, v);
    chk("overflow_set", ovf, 64'd1);
    tick(1'b0, g, v);
    chk("overflow_dropped", v, 64'd0);

    // Stall then stream 8 rows through a pointer wrap
    k = 1; n_pop = 0; cnt = 0;
    for (int i = 0; i < 40 && cnt < 8; i++) begin
      ready = (i >= 4);
      req   = 1'b1;
      tick(1'b0, g, v);
      if (i == 3) begin
        chk("full_gnt", g, 64'd0);
        chk("full_valid", v, 64'd1);
      end
      if (g) cnt++;
    end
    req = 1'b0;
    drain();
    chk("wrap_rows_out", n_pop, 64'd8);
    chk("overflow_sticky", ovf, 64'd1);

    // Reset with two rows stored
    req = 1'b1; ready = 1'b0;
    repeat (3) tick(1'b0, g, v);
    rst = 1'b1;
    #1;
    chk("midreset_valid", lut_valid, 64'd0);
    chk_row("midreset_row", lut_op, '0);
    chk("midreset_tag", lut_tag, 64'd0);
    chk("midreset_gnt", gnt, 64'd0);
    chk("midreset_overflow", ovf, 64'd0);
    sb.delete();
    pend = 1'b0;
    tick(1'b1, g, v);
    rst = 1'b0; ready = 1'b1; n_pop = 0;
    tick(1'b0, g, v);
    chk("post_reset_gnt", g, 64'd1);
    req = 1'b0;
    drain();
    chk("post_reset_rows", n_pop, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
